// File: rtl/stage_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback with a bounded memory wait.
// Optional macro PILLAR_INSTRET_EN adds a 32-bit retired-instruction counter on instret_o.
module stage_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt_i,
  input  logic [31:0] ir_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [2:0]  stage_o,
  output logic        ir_we_o,
  output logic        rf_we_o,
  output logic        pc_we_o,
  output logic        trap_o,
  output logic [31:0] instret_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
    S_MEMORY = 3'd4, S_WRITEBACK = 3'd5, S_UNUSED = 3'd6, S_TRAP = 3'd7
  } state_t;

  typedef enum logic [1:0] {C_ALU = 2'd0, C_BR = 2'd1, C_LD = 2'd2, C_ST = 2'd3} cls_t;

  state_t        state_r, state_s, retire_next_s;
  cls_t          cls_r, cls_s, dec_cls_s;
  logic          dec_valid_s;
  logic          rd_nz_r;
  logic [CW-1:0] wait_r;
  logic          timeout_s;
  logic          ir_unused_s;

  assign timeout_s     = (wait_r == CNT_LAST);
  assign retire_next_s = halt_i ? S_IDLE : S_FETCH;
  assign ir_unused_s   = ^ir_i[31:12];

  // Opcode classification; valid=0 marks an illegal opcode
  always_comb begin
    dec_valid_s = 1'b1;
    dec_cls_s   = C_ALU;
    case (ir_i[6:0])
      7'b0110111, 7'b0010111, 7'b1101111,
      7'b1100111, 7'b0010011, 7'b0110011: dec_cls_s = C_ALU;
      7'b1100011:                         dec_cls_s = C_BR;
      7'b0000011:                         dec_cls_s = C_LD;
      7'b0100011:                         dec_cls_s = C_ST;
      default:                            dec_valid_s = 1'b0;
    endcase
  end

  // Next-state logic plus the Mealy strobes (IR load on fetch ack, PC on retire)
  always_comb begin
    state_s = state_r;
    cls_s   = cls_r;
    ir_we_o = 1'b0;
    pc_we_o = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!halt_i) state_s = S_FETCH;
        else         state_s = S_IDLE;
      end
      S_FETCH: begin
        if (mem_ack_i) begin
          ir_we_o = 1'b1;
          state_s = S_DECODE;
        end else if (timeout_s) state_s = S_TRAP;
        else                    state_s = S_FETCH;
      end
      S_DECODE: begin
        if (dec_valid_s) begin
          cls_s   = dec_cls_s;
          state_s = S_EXECUTE;
        end else state_s = S_TRAP;
      end
      S_EXECUTE: begin
        case (cls_r)
          C_LD, C_ST: state_s = S_MEMORY;
          C_ALU:      state_s = S_WRITEBACK;
          C_BR: begin
            pc_we_o = 1'b1;
            state_s = retire_next_s;
          end
          default:    state_s = S_TRAP;
        endcase
      end
      S_MEMORY: begin
        // An ack on the last allowed cycle takes priority over the timeout
        if (mem_ack_i) begin
          if (cls_r == C_ST) begin
            pc_we_o = 1'b1;
            state_s = retire_next_s;
          end else state_s = S_WRITEBACK;
        end else if (timeout_s) state_s = S_TRAP;
        else                    state_s = S_MEMORY;
      end
      S_WRITEBACK: begin
        pc_we_o = 1'b1;
        state_s = retire_next_s;
      end
      S_TRAP:  state_s = S_TRAP;
      default: state_s = S_TRAP;
    endcase
  end

  // State, class and destination-nonzero registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cls_r   <= C_ALU;
      rd_nz_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cls_r   <= cls_s;
      if (state_r == S_DECODE) rd_nz_r <= (ir_i[11:7] != 5'd0);
      else                     rd_nz_r <= rd_nz_r;
    end
  end

  // Memory wait counter: cleared on every state change, counts unacked request cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_r <= '0;
    end else if (state_s != state_r) begin
      wait_r <= '0;
    end else if (((state_r == S_FETCH) || (state_r == S_MEMORY)) && !mem_ack_i) begin
      wait_r <= wait_r + CW'(1);
    end else begin
      wait_r <= wait_r;
    end
  end

  // Moore outputs decoded from the state registers only
  always_comb begin
    stage_o   = state_r;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    rf_we_o   = 1'b0;
    trap_o    = 1'b0;
    case (state_r)
      S_FETCH:     mem_req_o = 1'b1;
      S_MEMORY: begin
        mem_req_o = 1'b1;
        mem_we_o  = (cls_r == C_ST);
      end
      S_WRITEBACK: rf_we_o = rd_nz_r;
      S_TRAP:      trap_o = 1'b1;
      default:     mem_req_o = 1'b0;
    endcase
  end

`ifdef PILLAR_INSTRET_EN
  logic [31:0] instret_r;

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        instret_r <= 32'd0;
    else if (pc_we_o) instret_r <= instret_r + 32'd1;
    else              instret_r <= instret_r;
  end

  assign instret_o = instret_r;
`else
  assign instret_o = 32'd0;
`endif

endmodule

// File: tb/tb_stage_ctrl.sv
// Randomized bench: a per-instruction cycle-trace model derived from the sequencing rules drives ack/halt
// and predicts every output cycle by cycle.
module tb_stage_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0, reset = 1'b1, halt_i = 1'b1, mem_ack_i = 1'b0;
  logic [31:0] ir_i = 32'd0;
  logic        mem_req_o, mem_we_o, ir_we_o, rf_we_o, pc_we_o, trap_o;
  logic [2:0]  stage_o;
  logic [31:0] instret_o;

  stage_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .halt_i(halt_i), .ir_i(ir_i), .mem_ack_i(mem_ack_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .stage_o(stage_o), .ir_we_o(ir_we_o),
    .rf_we_o(rf_we_o), .pc_we_o(pc_we_o), .trap_o(trap_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] stage;
    logic req, we, irwe, rfwe, pcwe, trap, ack, halt;
  } rec_t;

  rec_t q[$];
  int   n_tests = 0, n_fail = 0, retired = 0, idle_max = 2;
  logic need_idle = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_instret();
`ifdef PILLAR_INSTRET_EN
    return 32'(retired);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [2:0] st, input logic req, we, irwe, rfwe, pcwe, trap, ack, halt);
    rec_t r;
    r = '{st, req, we, irwe, rfwe, pcwe, trap, ack, halt};
    q.push_back(r);
  endfunction

  // 0 ALU, 1 BR, 2 LD, 3 ST, 4 illegal
  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'h37, 7'h17, 7'h6f, 7'h67, 7'h13, 7'h33: return 0;
      7'h63: return 1;
      7'h03: return 2;
      7'h23: return 3;
      default: return 4;
    endcase
  endfunction

  task automatic push_trap();
    for (int i = 0; i < 3; i++) push(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rbit(), rbit());
  endtask

  // w wait cycles then an ack; w >= T means no ack ever, so T request cycles then trap
  task automatic gen_wait(input logic [2:0] st, input logic we, input int w, input logic fetch,
                          input logic retire, input logic h_end, output logic tr);
    tr = 1'b0;
    for (int i = 0; i < w && i < T; i++) push(st, 1'b1, we, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rbit());
    if (w >= T) begin
      tr = 1'b1;
      push_trap();
    end else begin
      push(st, 1'b1, we, fetch, 1'b0, retire, 1'b0, 1'b1, retire ? h_end : rbit());
    end
  endtask

  task automatic run_q(input int lim);
    rec_t r;
    logic [8:0] got, exp;
    for (int i = 0; i < q.size() && i < lim; i++) begin
      r = q[i];
      mem_ack_i = r.ack;
      halt_i    = r.halt;
      #1;
      exp = {r.stage, r.req, r.we, r.irwe, r.rfwe, r.pcwe, r.trap};
      got = {stage_o, mem_req_o, mem_we_o, ir_we_o, rf_we_o, pc_we_o, trap_o};
      check_eq("cyc{stage,req,we,irwe,rfwe,pcwe,trap}", 32'(got), 32'(exp));
      check_eq("instret", instret_o, exp_instret());
      @(posedge clk);
      if (r.pcwe) retired++;
      @(negedge clk);
    end
    q.delete();
  endtask

  task automatic run_instr(input logic [31:0] ir, input int fw, input int mw, input logic h_end,
                           input int lim, output logic trapped);
    int c, k;
    logic rdnz;
    q.delete();
    if (need_idle) begin
      k = $urandom_range(0, idle_max);
      for (int i = 0; i < k; i++) push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rbit(), 1'b1);
      push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rbit(), 1'b0);
      need_idle = 1'b0;
    end
    ir_i = ir;
    c    = cls_of(ir[6:0]);
    rdnz = (ir[11:7] != 5'd0);
    gen_wait(3'd1, 1'b0, fw, 1'b1, 1'b0, 1'b0, trapped);
    if (!trapped) begin
      push(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rbit(), rbit());
      if (c == 4) begin
        trapped = 1'b1;
        push_trap();
      end else if (c == 1) begin
        push(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rbit(), h_end);
      end else begin
        push(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rbit(), rbit());
        if (c >= 2) gen_wait(3'd4, (c == 3), mw, 1'b0, (c == 3), h_end, trapped);
        if (!trapped && c != 3) push(3'd5, 1'b0, 1'b0, 1'b0, rdnz, 1'b1, 1'b0, rbit(), h_end);
      end
    end
    if (!trapped && h_end) need_idle = 1'b1;
    run_q(lim);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("reset_outs", 32'({stage_o, mem_req_o, mem_we_o, ir_we_o, rf_we_o, pc_we_o, trap_o}), 32'd0);
    check_eq("reset_instret", instret_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    retired   = 0;
    need_idle = 1'b1;
  endtask

  logic [31:0] ir_rand;
  logic        tr;
  int          op_idx, fw, mw;
  logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h13, 7'h33, 7'h63, 7'h03, 7'h23};

  initial begin
    @(negedge clk);
    idle_max = 3;
    do_reset();
    run_instr(32'h00308133, 0, 0, 1'b0, 1000, tr);  // add x2,x1,x3
    idle_max = 2;
    run_instr(32'h0000A183, 0, 2, 1'b0, 1000, tr);  // lw, ack on 3rd MEMORY cycle
    run_instr(32'h0020A023, 0, 0, 1'b0, 1000, tr);  // sw
    run_instr(32'h00000013, 0, 0, 1'b0, 1000, tr);  // addi x0
    run_instr(32'h00000063, 1, 0, 1'b1, 1000, tr);  // beq, halt at retire
    run_instr(32'h00308133, T - 1, 0, 1'b0, 1000, tr);  // ack on the last allowed fetch cycle
    run_instr(32'h00308133, T, 0, 1'b0, 1000, tr);      // fetch timeout
    do_reset();
    run_instr(32'hFFFFFFFF, 0, 0, 1'b0, 1000, tr);      // illegal opcode
    do_reset();

    for (int n = 0; n < 200; n++) begin
      ir_rand = $urandom;
      op_idx  = $urandom_range(0, 9);
      ir_rand[6:0] = (op_idx == 9) ? 7'h7f : ops[op_idx];
      fw = ($urandom_range(0, 24) == 0) ? T : $urandom_range(0, T - 1);
      mw = ($urandom_range(0, 12) == 0) ? T : $urandom_range(0, T - 1);
      run_instr(ir_rand, fw, mw, ($urandom_range(0, 4) == 0), 1000, tr);
      if (tr) do_reset();
    end

    do_reset();
    for (int n = 0; n < 5; n++) run_instr(32'h00000063, 0, 0, 1'b0, 1000, tr);
    run_instr(32'h0000A183, 0, 3, 1'b0, 4, tr);  // stop inside MEMORY
    check_eq("mid_mem_req", 32'(mem_req_o), 32'd1);
    check_eq("mid_mem_instret", instret_o, exp_instret());
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_outs", 32'({stage_o, mem_req_o, mem_we_o, ir_we_o, rf_we_o, pc_we_o, trap_o}), 32'd0);
    check_eq("async_rst_instret", instret_o, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    retired   = 0;
    need_idle = 1'b1;
    idle_max  = 0;
    run_instr(32'h00308133, 0, 0, 1'b0, 1000, tr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
